// File: rtl/alu_issue_ctrl_if.sv
// Instruction-issue handshake bundle between an instruction source and alu_issue_ctrl.
interface alu_issue_ctrl_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [3:0] instr_rdest;
    logic [3:0] instr_rsrc;
    logic [7:0] instr_imm;
    logic       instr_imm_sel;

    modport master (
        output instr_valid,
        output instr_op,
        output instr_rdest,
        output instr_rsrc,
        output instr_imm,
        output instr_imm_sel,
        input  instr_ready
    );

    modport slave (
        input  instr_valid,
        input  instr_op,
        input  instr_rdest,
        input  instr_rsrc,
        input  instr_imm,
        input  instr_imm_sel,
        output instr_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Operand-issue and writeback controller for a combinational 16-bit ALU:
// one instruction in flight, IDLE -> EXEC -> WB, 16 x 16-bit register file and 5-bit PSR.
module alu_issue_ctrl (
    input  logic                  clk,
    input  logic                  reset_n,
    alu_issue_ctrl_if.slave       instr,
    output logic [15:0]           alu_A,
    output logic [15:0]           alu_B,
    output logic                  alu_carryIn,
    output logic [3:0]            alu_Opcode,
    input  logic [15:0]           alu_C,
    input  logic [4:0]            alu_Flags,
    output logic [4:0]            psr,
    output logic                  done,
    input  logic [3:0]            dbg_addr,
    output logic [15:0]           dbg_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;
    localparam logic [3:0] OP_CMPU = 4'b1000;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] opa_q, opa_d, opb_q, opb_d;
    logic [3:0]  op_q, op_d, rd_q, rd_d;
    logic        cin_q, cin_d;
    logic [15:0] res_q, res_d;
    logic [4:0]  resf_q, resf_d;
    logic [4:0]  psr_q, psr_d;
    logic        done_q, done_d;
    logic [15:0] rf_q [16];
    logic [15:0] rf_d [16];
    logic        accept_s;

    assign instr.instr_ready = (state_q == ST_IDLE);
    assign accept_s          = instr.instr_valid && (state_q == ST_IDLE);

    // Sequencing: one accept, one execute cycle, one writeback cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand staging; the carry is sampled from the PSR at accept and held with the operands.
    always_comb begin
        opa_d = opa_q;
        opb_d = opb_q;
        op_d  = op_q;
        rd_d  = rd_q;
        cin_d = cin_q;
        if (accept_s) begin
            opa_d = rf_q[instr.instr_rdest];
            opb_d = instr.instr_imm_sel ? sext8(instr.instr_imm) : rf_q[instr.instr_rsrc];
            op_d  = instr.instr_op;
            rd_d  = instr.instr_rdest;
            cin_d = psr_q[0];
        end else begin
            opa_d = opa_q;
            opb_d = opb_q;
            op_d  = op_q;
            rd_d  = rd_q;
            cin_d = cin_q;
        end
    end

    // Result capture at the end of EXEC, retirement into PSR/register file at the end of WB.
    always_comb begin
        res_d  = res_q;
        resf_d = resf_q;
        psr_d  = psr_q;
        rf_d   = rf_q;
        done_d = 1'b0;
        if (state_q == ST_EXEC) begin
            res_d  = alu_C;
            resf_d = alu_Flags;
        end else begin
            res_d  = res_q;
            resf_d = resf_q;
        end
        if (state_q == ST_WB) begin
            psr_d  = resf_q;
            done_d = 1'b1;
            // Compare-unsigned only updates flags.
            if (op_q != OP_CMPU) begin
                rf_d[rd_q] = res_q;
            end else begin
                rf_d = rf_q;
            end
        end else begin
            psr_d  = psr_q;
            done_d = 1'b0;
        end
    end

    // State, staging, result and architectural registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            opa_q   <= 16'h0000;
            opb_q   <= 16'h0000;
            op_q    <= 4'h0;
            rd_q    <= 4'h0;
            cin_q   <= 1'b0;
            res_q   <= 16'h0000;
            resf_q  <= 5'h00;
            psr_q   <= 5'h00;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            cin_q   <= cin_d;
            res_q   <= res_d;
            resf_q  <= resf_d;
            psr_q   <= psr_d;
            done_q  <= done_d;
            rf_q    <= rf_d;
        end
    end

    assign alu_A       = opa_q;
    assign alu_B       = opb_q;
    assign alu_Opcode  = op_q;
    assign alu_carryIn = cin_q;
    assign psr         = psr_q;
    assign done        = done_q;
    assign dbg_data    = rf_q[dbg_addr];

endmodule
